rst_n_seq: RTL and testbench



---
 rtl/rst_n_seq_pkg.sv | 35 +++
 rtl/rst_n_seq_timer.sv | 32 +++
 rtl/rst_n_seq.sv | 167 ++++++++++++++++
 tb/tb_rst_n_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_n_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
// The FAULT state only exists when RST_N_SEQ_TIMEOUT_EN is defined.
package rst_n_seq_pkg;

`ifdef RST_N_SEQ_TIMEOUT_EN
   typedef enum logic [1:0] {
      ST_HOLD,
      ST_WAIT,
      ST_DONE,
      ST_FAULT
   } seq_state_t;
`else
   typedef enum logic [1:0] {
      ST_HOLD,
      ST_WAIT,
      ST_DONE
   } seq_state_t;
`endif

   // The shared timer must hold both HOLD_CYCLES-1 and TIMEOUT_CYCLES-1.
   function automatic int CNT_W(input int hold_cycles, input int timeout_cycles);
      int hold_w;
      int tmo_w;
      int width;
      hold_w = $clog2(hold_cycles);
      tmo_w  = $clog2(timeout_cycles);
      width  = (hold_w > tmo_w) ? hold_w : tmo_w;
      return (width < 1) ? 1 : width;
   endfunction

   function automatic int idx_w(input int num_stages);
      return (num_stages > 1) ? $clog2(num_stages) : 1;
   endfunction

endpackage

// File: rtl/rst_n_seq_timer.sv
// Loadable down-counter with zero flag, shared between the reset hold period
// and the per-stage acknowledgement timeout.
module rst_n_seq_timer
   import rst_n_seq_pkg::*;
#(
   parameter int CNT_WIDTH = 4,
   parameter logic [CNT_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                 clk,
   input  logic                 sync_rst_n,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic                 dec,
   output logic                 zero
);

   logic [CNT_WIDTH-1:0] count_q;

   // Saturates at zero so a late decrement cannot wrap into a long wait.
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         count_q <= RESET_VAL;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/rst_n_seq.sv
// Reset release sequencer: releases stage resets in order, each after the previous
// stage acknowledges. Optional acknowledgement timeout via RST_N_SEQ_TIMEOUT_EN.
module rst_n_seq
   import rst_n_seq_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              sync_rst_n,
   input  logic                              sw_rst_req,
   input  logic [NUM_STAGES-1:0]             stage_ready,
   output logic [NUM_STAGES-1:0]             stage_rst_n,
   output logic                              all_ready,
   output logic                              timeout_err,
   output logic [idx_w(NUM_STAGES)-1:0]      fail_stage
);

   localparam int IDX_W = idx_w(NUM_STAGES);
   localparam int CW    = CNT_W(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
`ifdef RST_N_SEQ_TIMEOUT_EN
   localparam logic [CW-1:0]    TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
`endif

   seq_state_t             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_STAGES-1:0]  stage_q, stage_d;
   logic                   all_ready_q, all_ready_d;
   logic                   restart;
   logic                   timer_load;
   logic                   timer_dec;
   logic [CW-1:0]          timer_val;
   logic                   timer_zero;
`ifdef RST_N_SEQ_TIMEOUT_EN
   logic                   err_q, err_d;
   logic [IDX_W-1:0]       fail_q, fail_d;
`endif

   rst_n_seq_timer #(
      .CNT_WIDTH (CW),
      .RESET_VAL (HOLD_LOAD)
   ) u_timer (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .load       (timer_load),
      .load_val   (timer_val),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   assign restart = sw_rst_req && (state_q != ST_HOLD);

   // A software restart overrides any ready or timeout event on the same edge.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      stage_d     = stage_q;
      all_ready_d = all_ready_q;
      timer_load  = 1'b0;
      timer_dec   = 1'b0;
      timer_val   = HOLD_LOAD;
`ifdef RST_N_SEQ_TIMEOUT_EN
      err_d       = err_q;
      fail_d      = fail_q;
`endif
      if (restart) begin
         state_d     = ST_HOLD;
         idx_d       = '0;
         stage_d     = '0;
         all_ready_d = 1'b0;
         timer_load  = 1'b1;
`ifdef RST_N_SEQ_TIMEOUT_EN
         err_d       = 1'b0;
         fail_d      = '0;
`endif
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (timer_zero) begin
                  state_d = ST_WAIT;
                  idx_d   = '0;
                  stage_d = NUM_STAGES'(1);
`ifdef RST_N_SEQ_TIMEOUT_EN
                  timer_load = 1'b1;
                  timer_val  = TIMEOUT_LOAD;
`endif
               end else begin
                  timer_dec = 1'b1;
               end
            end
            ST_WAIT: begin
               if (stage_ready[idx_q]) begin
                  if (idx_q == LAST_IDX) begin
                     state_d     = ST_DONE;
                     all_ready_d = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     stage_d = (stage_q << 1) | NUM_STAGES'(1);
`ifdef RST_N_SEQ_TIMEOUT_EN
                     timer_load = 1'b1;
                     timer_val  = TIMEOUT_LOAD;
`endif
                  end
`ifdef RST_N_SEQ_TIMEOUT_EN
               end else if (timer_zero) begin
                  state_d = ST_FAULT;
                  err_d   = 1'b1;
                  fail_d  = idx_q;
               end else begin
                  timer_dec = 1'b1;
`endif
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
`ifdef RST_N_SEQ_TIMEOUT_EN
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
`endif
            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         state_q     <= ST_HOLD;
         idx_q       <= '0;
         stage_q     <= '0;
         all_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         all_ready_q <= all_ready_d;
      end
   end

`ifdef RST_N_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         err_q  <= 1'b0;
         fail_q <= '0;
      end else begin
         err_q  <= err_d;
         fail_q <= fail_d;
      end
   end

   assign timeout_err = err_q;
   assign fail_stage  = fail_q;
`else
   assign timeout_err = 1'b0;
   assign fail_stage  = '0;
`endif

   assign stage_rst_n = stage_q;
   assign all_ready   = all_ready_q;

endmodule

// File: tb/tb_rst_n_seq.sv
// Self-checking bench for rst_n_seq against an event-level reference model.
// Honours RST_N_SEQ_TIMEOUT_EN for the timeout scenarios.
module tb_rst_n_seq;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int TMO  = 8;
   localparam int IW   = 2;
   localparam int P_HOLD  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_DONE  = 2;
   localparam int P_FAULT = 3;
`ifdef RST_N_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          sync_rst_n;
   logic          sw_rst_req;
   logic [N-1:0]  stage_ready;
   logic [N-1:0]  stage_rst_n;
   logic          all_ready;
   logic          timeout_err;
   logic [IW-1:0] fail_stage;

   int checks   = 0;
   int failures = 0;

   int m_phase;
   int m_hold_left;
   int m_released;
   int m_wait_edges;
   int m_fail;

   always #5 clk = ~clk;

   rst_n_seq #(
      .NUM_STAGES     (N),
      .HOLD_CYCLES    (HOLD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .sync_rst_n  (sync_rst_n),
      .sw_rst_req  (sw_rst_req),
      .stage_ready (stage_ready),
      .stage_rst_n (stage_rst_n),
      .all_ready   (all_ready),
      .timeout_err (timeout_err),
      .fail_stage  (fail_stage)
   );

   // Reference model: counts edges left in hold, number of released stages,
   // and edges spent waiting on the current stage.
   task automatic model_reset();
      m_phase      = P_HOLD;
      m_hold_left  = HOLD;
      m_released   = 0;
      m_wait_edges = 0;
      m_fail       = 0;
   endtask

   task automatic model_step();
      if (!sync_rst_n) begin
         model_reset();
      end else if (sw_rst_req && m_phase != P_HOLD) begin
         model_reset();
      end else if (m_phase == P_HOLD) begin
         m_hold_left--;
         if (m_hold_left == 0) begin
            m_phase      = P_WAIT;
            m_released   = 1;
            m_wait_edges = 0;
         end
      end else if (m_phase == P_WAIT) begin
         m_wait_edges++;
         if (stage_ready[m_released-1]) begin
            if (m_released < N) begin
               m_released++;
               m_wait_edges = 0;
            end else begin
               m_phase = P_DONE;
            end
         end else if (TMO_EN && m_wait_edges == TMO) begin
            m_phase = P_FAULT;
            m_fail  = m_released - 1;
         end
      end
   endtask

   function automatic logic [N+IW+1:0] exp_vec();
      int thermo;
      int fail_v;
      logic [N-1:0]  s;
      logic [IW-1:0] f;
      thermo = (1 << m_released) - 1;
      fail_v = (m_phase == P_FAULT) ? m_fail : 0;
      s = thermo[N-1:0];
      f = fail_v[IW-1:0];
      return {s, (m_phase == P_DONE), (m_phase == P_FAULT), f};
   endfunction

   function automatic logic [N+IW+1:0] got_vec();
      return {stage_rst_n, all_ready, timeout_err, fail_stage};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      sync_rst_n = 1'b0;
      sw_rst_req = 1'b0;
      model_reset();
      @(negedge clk);
      sync_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      sync_rst_n  = 1'b0;
      sw_rst_req  = 1'b0;
      stage_ready = '1;
      model_reset();
      #3;
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("[TB] FAIL reset_state got=%b expected=%b", got_vec(), exp_vec());
      end
      @(negedge clk);
      sync_rst_n = 1'b1;
      step();
      checks++;
      if (stage_rst_n !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_hold_first_edge got=%b expected=0000", stage_rst_n);
      end
   endtask

   task automatic test_ready_high();
      apply_reset();
      stage_ready = '1;
      for (int e = 1; e <= 22; e++) begin
         step();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL ready_high edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
         if (e == 15 || e == 16 || e == 19) begin
            checks++;
            if (stage_rst_n !== ((e == 15) ? 4'b0000 : (e == 16) ? 4'b0001 : 4'b1111)) begin
               failures++;
               $display("[TB] FAIL ready_high_latency edge=%0d got=%b", e, stage_rst_n);
            end
         end
         if (e == 19 || e == 20) begin
            checks++;
            if (all_ready !== (e == 20)) begin
               failures++;
               $display("[TB] FAIL all_ready_latency edge=%0d got=%b expected=%b", e, all_ready, (e == 20));
            end
         end
      end
   endtask

   task automatic test_delayed_ready();
      int rise1;
      apply_reset();
      stage_ready = 4'b1101;
      rise1 = -1;
      for (int e = 1; e <= 40; e++) begin
         step();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL delayed_ready edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
         if (rise1 < 0 && stage_rst_n[1] === 1'b1) rise1 = e;
         if (rise1 > 0 && e == rise1 + 10) stage_ready[1] = 1'b1;
         if (!TMO_EN && rise1 > 0 && (e == rise1 + 10 || e == rise1 + 11)) begin
            checks++;
            if (stage_rst_n[2] !== (e == rise1 + 11)) begin
               failures++;
               $display("[TB] FAIL delayed_stage2 edge=%0d got=%b", e, stage_rst_n[2]);
            end
         end
         if (!TMO_EN && (e == 29 || e == 30)) begin
            checks++;
            if (all_ready !== (e == 30)) begin
               failures++;
               $display("[TB] FAIL delayed_all_ready edge=%0d got=%b expected=%b", e, all_ready, (e == 30));
            end
         end
      end
   endtask

   task automatic test_sw_req();
      apply_reset();
      stage_ready = '1;
      for (int e = 1; e <= 24; e++) step();
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      checks++;
      if (stage_rst_n !== 4'b0000 || all_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL sw_req_clear got=%b/%b expected=0000/0", stage_rst_n, all_ready);
      end
      for (int e = 1; e <= 22; e++) begin
         if (e == 5) sw_rst_req = 1'b1;
         step();
         sw_rst_req = 1'b0;
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL sw_req_rerun edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
         if (e == 16 || e == 20) begin
            checks++;
            if ({stage_rst_n, all_ready} !== ((e == 16) ? 5'b0001_0 : 5'b1111_1)) begin
               failures++;
               $display("[TB] FAIL sw_req_timing edge=%0d got=%b%b", e, stage_rst_n, all_ready);
            end
         end
      end
   endtask

   task automatic test_async_reset_mid();
      apply_reset();
      stage_ready = 4'b0011;
      for (int e = 1; e <= 22; e++) step();
      checks++;
      if (stage_rst_n !== 4'b0111) begin
         failures++;
         $display("[TB] FAIL async_pre got=%b expected=0111", stage_rst_n);
      end
      #2;
      sync_rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (got_vec() !== {(N+IW+2){1'b0}}) begin
         failures++;
         $display("[TB] FAIL async_clear got=%b expected=0", got_vec());
      end
      @(negedge clk);
      sync_rst_n  = 1'b1;
      stage_ready = '1;
      for (int e = 1; e <= 22; e++) begin
         step();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL async_restart edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      stage_ready = 4'b1011;
      for (int e = 1; e <= 120; e++) begin
         step();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL stall edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
      end
      checks++;
      if (got_vec() !== {4'b0111, 1'b0, TMO_EN, (TMO_EN ? 2'd2 : 2'd0)}) begin
         failures++;
         $display("[TB] FAIL stall_state got=%b expected=%b", got_vec(),
                  {4'b0111, 1'b0, TMO_EN, (TMO_EN ? 2'd2 : 2'd0)});
      end
      if (TMO_EN) begin
         sw_rst_req = 1'b1;
         step();
         sw_rst_req = 1'b0;
         checks++;
         if (timeout_err !== 1'b0 || fail_stage !== 2'd0 || stage_rst_n !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL stall_sw_clear err=%b fail=%0d stage=%b expected 0/0/0000",
                     timeout_err, fail_stage, stage_rst_n);
         end
      end else begin
         stage_ready[2] = 1'b1;
         step();
         step();
         checks++;
         if (all_ready !== 1'b1 || stage_rst_n !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL stall_complete got=%b/%b expected=1111/1", stage_rst_n, all_ready);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int e = 1; e <= 600; e++) begin
         stage_ready = N'($urandom);
         sw_rst_req  = ($urandom_range(0, 59) == 0);
         step();
         checks++;
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL random edge=%0d got=%b expected=%b", e, got_vec(), exp_vec());
         end
      end
      sw_rst_req = 1'b0;
   endtask

   initial begin
      sync_rst_n  = 1'b0;
      sw_rst_req  = 1'b0;
      stage_ready = '0;
      test_reset();
      test_ready_high();
      test_delayed_ready();
      test_sw_req();
      test_async_reset_mid();
      test_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
